// File: rtl/ldd_sched_pkg.sv
// Shared types and mode encodings for the ldd decode grant scheduler.
package ldd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_COOL  = 2'd2
    } sched_state_t;

    localparam logic [2:0] MODE_FIXED = 3'b000;
    localparam logic [2:0] MODE_RR    = 3'b001;
    localparam logic [2:0] MODE_SHOT  = 3'b010;

    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode == MODE_FIXED) || (mode == MODE_RR) || (mode == MODE_SHOT);
    endfunction

endpackage

// File: rtl/ldd_prio_pick.sv
// Rotating priority picker: first set bit of elig_i searching upward from start_i, wrapping.
module ldd_prio_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [1:0]       start_i,
    output logic             found_o,
    output logic [1:0]       idx_o
);

    // Scan from the far end back toward start_i so the candidate nearest start_i wins.
    always_comb begin
        logic [1:0] cand;
        found_o = 1'b0;
        idx_o   = 2'd0;
        cand    = 2'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = start_i + 2'(k);
            if (elig_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/ldd_grant_sched.sv
// Registered req/gnt scheduler for the shared ldd decode resource.
// state | meaning: IDLE arbitrate | GRANT owner holds resource | COOL one-cycle gap after hold expiry
module ldd_grant_sched
    import ldd_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [2:0]        mode_i,
    input  logic              inhibit_i,
    input  logic [N_REQ-1:0]  req_i,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [1:0]        gnt_idx_o,
    output logic              busy_o,
    output logic [HOLD_W-1:0] hold_cnt_o,
    output logic              expire_o
);

    localparam logic [N_REQ-1:0]  ONE_HOT0 = N_REQ'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    sched_state_t      state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  mask_q;
    logic [1:0]        gnt_idx_q;
    logic [1:0]        rr_ptr_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              expire_q;
    logic [2:0]        cur_mode_q;

    logic [N_REQ-1:0]  elig_d;
    logic [1:0]        start_d;
    logic [1:0]        pick_idx_d;
    logic              pick_found_d;
    logic              grant_ok_d;

    // mask_q is only non-zero in the IDLE cycle that follows COOL.
    assign elig_d     = req_i & ~mask_q;
    assign start_d    = (mode_i == MODE_RR) ? rr_ptr_q : 2'd0;
    assign grant_ok_d = pick_found_d && !inhibit_i && mode_legal(mode_i);

    ldd_prio_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .elig_i  (elig_d),
        .start_i (start_d),
        .found_o (pick_found_d),
        .idx_o   (pick_idx_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            mask_q     <= '0;
            gnt_idx_q  <= 2'd0;
            rr_ptr_q   <= 2'd0;
            hold_cnt_q <= '0;
            expire_q   <= 1'b0;
            cur_mode_q <= MODE_FIXED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mask_q <= '0;
                    if (grant_ok_d) begin
                        state_q    <= ST_GRANT;
                        gnt_q      <= ONE_HOT0 << pick_idx_d;
                        gnt_idx_q  <= pick_idx_d;
                        hold_cnt_q <= HOLD_W'(1);
                        cur_mode_q <= mode_i;
                        if (mode_i == MODE_RR) begin
                            rr_ptr_q <= pick_idx_d + 2'd1;
                        end
                    end
                end
                ST_GRANT: begin
                    if (!req_i[gnt_idx_q] || (cur_mode_q == MODE_SHOT)) begin
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_MAX) begin
                        state_q    <= ST_COOL;
                        gnt_q      <= '0;
                        hold_cnt_q <= '0;
                        expire_q   <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_COOL: begin
                    state_q  <= ST_IDLE;
                    expire_q <= 1'b0;
                    mask_q   <= ONE_HOT0 << gnt_idx_q;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    gnt_q      <= '0;
                    mask_q     <= '0;
                    hold_cnt_q <= '0;
                    expire_q   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign gnt_idx_o  = gnt_idx_q;
    assign busy_o     = (gnt_q != '0);
    assign hold_cnt_o = hold_cnt_q;
    assign expire_o   = expire_q;

endmodule

// File: doc/ldd_grant_sched.md
# ldd_grant_sched

Sequential grant scheduler for the shared `ldd` decode resource. The block arbitrates four request lines into a registered one-hot grant, using either fixed or round-robin priority. Each grant is held until the owner releases it or a hold limit expires. It sits in front of the `ldd` decode datapath and replaces the purely combinational priority chain with a cycle-accurate req/gnt handshake.

## Interface
- `N_REQ`, default 4: number of requesters. Fixed at 4 for this release; index 0 is the highest fixed priority.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership. Legal range is 2..255.
- `HOLD_W`, default `$clog2(MAX_HOLD+1)`: width of the hold counter.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `mode` in 3: arbitration mode, sampled only in IDLE.
  - 3'b000: fixed priority.
  - 3'b001: round-robin.
  - 3'b010: single-shot, meaning fixed priority with every grant lasting exactly 1 cycle.
  - All other values: disabled, no new grants.
- `inhibit` in 1: blocks new grants while high; has no effect on a grant in progress.
- `req` in `N_REQ`: level requests; a requester holds its bit high for as long as it wants the resource.
- `gnt` out `N_REQ`: registered one-hot grant, or all zeros.
- `gnt_idx` out 2: index of the current or most recent owner.
- `busy` out 1: high exactly when `gnt` != 0.
- `hold_cnt` out `HOLD_W`: number of cycles the current grant has been held, starting at 1 in the first grant cycle.
- `expire` out 1: one-cycle pulse in the first cycle after a grant ends by hold expiry.

## Operation
- States are IDLE, GRANT and COOL, held in a registered FSM.
- In IDLE the block computes `elig = req & ~mask`.
  - `mask` is the expired owner's bit if the previous state was COOL; otherwise it is 0.
  - If `elig` != 0, `inhibit` = 0 and `mode` is legal, the block picks a winner and moves to GRANT.
  - Otherwise it stays in IDLE.
- Winner selection:
  - Fixed priority and single-shot: the lowest index in `elig` wins.
  - Round-robin: the search starts at `rr_ptr` and wraps modulo `N_REQ`. On each grant, `rr_ptr` becomes winner+1 mod `N_REQ`. `rr_ptr` is updated only in round-robin mode.
- On entry to GRANT: `gnt` = one-hot(winner), `gnt_idx` = winner, `hold_cnt` = 1. The mode in effect is latched as `cur_mode`.
- In GRANT, evaluated each cycle in this order:
  - If `req[gnt_idx]` = 0, go to IDLE (release).
  - Else if `cur_mode` is single-shot, go to IDLE.
  - Else if `hold_cnt` == `MAX_HOLD`, go to COOL (expiry).
  - Else stay in GRANT and increment `hold_cnt`.
- COOL lasts 1 cycle: `gnt` = 0 and `expire` = 1. It then always goes to IDLE, and the expired owner is masked for that single arbitration.
- `hold_cnt` is 0 whenever not in GRANT. It saturates at `MAX_HOLD` and never wraps.
- A mode or inhibit change during GRANT or COOL takes effect at the next IDLE evaluation only.
- Requests from non-owners during GRANT are ignored; nothing is queued or latched.

## Timing
- Reset values on the first `clk` edge with `rst_n` = 0: state IDLE, `gnt` = 0, `gnt_idx` = 0, `busy` = 0, `hold_cnt` = 0, `expire` = 0, `rr_ptr` = 0, `cur_mode` = 3'b000.
- Reset asserted mid-grant drops `gnt` at that edge. No `expire` pulse is produced.
- Grant latency: `req` high at edge t while in IDLE gives `gnt` high after edge t.
- Release: if the owner's `req` is low at edge t, `gnt` is 0 after edge t. The earliest next grant is after edge t+1, so the minimum gap between grants is 1 cycle.
- Expiry: the grant lasts exactly `MAX_HOLD` cycles, then there is 1 COOL cycle and 1 IDLE cycle. A different requester can therefore be granted `MAX_HOLD`+2 cycles after the expired grant began.
- The owner may retain the resource by dropping and re-raising `req` only after the 1-cycle gap, and only subject to normal arbitration.
- Simultaneous requests are resolved within the same cycle by the active priority rule. There are no combinational paths from inputs to outputs.

## Structure
- Package `ldd_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, GRANT, COOL);
  - the mode constants `MODE_FIXED`, `MODE_RR`, `MODE_SHOT`;
  - the function `mode_legal()`.
- Sub-module `ldd_prio_pick` is combinational. It takes `elig[N_REQ]` and `start[2]` and returns `found` and `idx[2]`. Fixed priority uses `start` = 0.
- Top level contains the FSM, `hold_cnt`, `rr_ptr` and the output registers.

## Test plan
- Fixed priority with `req` = 4'b1010 from IDLE: after 1 cycle, `gnt` = 4'b0010 and `gnt_idx` = 1. Drop `req[1]`: next cycle `gnt` = 0, and the cycle after that `gnt` = 4'b1000.
- Round-robin with `req` = 4'b1111 held constant and a release after each grant: grants go in the order 0, 1, 2, 3, 0, and `rr_ptr` wraps 3 -> 0.
- Expiry with `MAX_HOLD` = 8 and `req` = 4'b0011 held high, fixed mode: `gnt` = 4'b0001 for 8 cycles with `hold_cnt` going 1..8, then `expire` = 1 for 1 cycle, then `gnt` = 4'b0010.
- Single-shot mode with `req[2]` held high: `gnt` = 4'b0100 pulses for 1 cycle and repeats every 2 cycles.
- Mode change and inhibit:
  - `inhibit` = 1 with `req` = 4'b0001: `gnt` stays 0.
  - Set `inhibit` = 1 mid-grant: the grant continues until release.
  - `mode` = 3'b111: no grants are issued.
- Reset mid-grant with `rst_n` low for 1 edge at `hold_cnt` = 5: all outputs read 0, `expire` = 0, and after reset release round-robin restarts at index 0.
